// File: rtl/rr_mux_reg.sv
// NCH-way registered selector with valid/ready handshake per channel.
// Fixed-priority or round-robin arbitration, plus a forced-select override.
module rr_mux_reg #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  parameter  int MODE  = 1,
  localparam int IDXW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 force_en,
  input  logic [IDXW-1:0]      force_sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  ptr_nxt;
  logic             load_en;
  logic             xfer;
  logic             fp_hit;
  logic [IDXW-1:0]  fp_idx;
  logic             rr_hit;
  logic [IDXW-1:0]  rr_idx;
  logic             frc_hit;
  logic             grant_hit;
  logic [IDXW-1:0]  grant;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_hit;

  always_comb begin : fixed_prio
    fp_hit = 1'b0;
    fp_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_hit = 1'b1;
        fp_idx = IDXW'(i);
      end
    end
  end

  // Walk the search order backwards so the last hit is the first in ptr order.
  always_comb begin : round_robin
    int j;
    j      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (j < NCH && in_valid[j]) begin
        rr_hit = 1'b1;
        rr_idx = IDXW'(j);
      end
    end
  end

  // Compare against every legal index so an out-of-range force_sel never hits.
  always_comb begin : forced
    frc_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (force_sel == IDXW'(i) && in_valid[i]) frc_hit = 1'b1;
    end
  end

  always_comb begin : grant_sel
    grant_hit = 1'b0;
    grant     = '0;
    if (force_en) begin
      grant_hit = frc_hit;
      grant     = force_sel;
    end else if (MODE == 1) begin
      grant_hit = rr_hit;
      grant     = rr_idx;
    end else begin
      grant_hit = fp_hit;
      grant     = fp_idx;
    end
  end

  always_comb begin : data_sel
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == IDXW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : ready_gen
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = rst_n && xfer && (grant == IDXW'(i));
    end
  end

  assign ptr_nxt = (grant == IDXW'(NCH - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= grant_hit;
      if (grant_hit) begin
        out_data <= sel_data;
        out_ch   <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (MODE == 1 && xfer && !force_en) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: round-robin NCH=4, fixed-priority NCH=4,
// and round-robin NCH=3 instances driven one after another.
module tb_rr_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]   a_in_valid, a_in_ready;
  logic [127:0] a_in_data;
  logic         a_force_en, a_out_valid, a_out_ready;
  logic [1:0]   a_force_sel, a_out_ch;
  logic [31:0]  a_out_data;

  logic [3:0]   b_in_valid, b_in_ready;
  logic [127:0] b_in_data;
  logic         b_force_en, b_out_valid, b_out_ready;
  logic [1:0]   b_force_sel, b_out_ch;
  logic [31:0]  b_out_data;

  logic [2:0]   c_in_valid, c_in_ready;
  logic [95:0]  c_in_data;
  logic         c_force_en, c_out_valid, c_out_ready;
  logic [1:0]   c_force_sel, c_out_ch;
  logic [31:0]  c_out_data;

  rr_mux_reg #(.WIDTH(32), .NCH(4), .MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .force_en(a_force_en), .force_sel(a_force_sel),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_ready(a_out_ready));

  rr_mux_reg #(.WIDTH(32), .NCH(4), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .force_en(b_force_en), .force_sel(b_force_sel),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready));

  rr_mux_reg #(.WIDTH(32), .NCH(3), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .force_en(c_force_en), .force_sel(c_force_sel),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_ready(c_out_ready));

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch   = 4'(ch);
    e.data = d;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A word leaves the output register on the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) chk("a_sb_empty", 64'(q_a.size()), 1);
      else begin
        e = q_a.pop_front();
        chk("a_data", a_out_data, e.data);
        chk("a_ch", a_out_ch, e.ch);
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) chk("b_sb_empty", 64'(q_b.size()), 1);
      else begin
        e = q_b.pop_front();
        chk("b_data", b_out_data, e.data);
        chk("b_ch", b_out_ch, e.ch);
      end
    end
    if (rst_n && c_out_valid && c_out_ready) begin
      if (q_c.size() == 0) chk("c_sb_empty", 64'(q_c.size()), 1);
      else begin
        e = q_c.pop_front();
        chk("c_data", c_out_data, e.data);
        chk("c_ch", c_out_ch, e.ch);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 4'hF; a_in_data = {32'h13, 32'h12, 32'h11, 32'h10};
    a_force_en = 1'b0; a_force_sel = 2'd0; a_out_ready = 1'b1;
    b_in_valid = 4'h0; b_in_data = '0; b_force_en = 1'b0; b_force_sel = 2'd0; b_out_ready = 1'b1;
    c_in_valid = 3'h0; c_in_data = {32'h22, 32'h21, 32'h20};
    c_force_en = 1'b0; c_force_sel = 2'd0; c_out_ready = 1'b1;
    #3;
    chk("rst_in_ready", a_in_ready, 4'h0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_ch", a_out_ch, 0);
    step(); step();
    rst_n = 1'b1;
    #1;

    // round-robin, all channels requesting
    for (int k = 0; k < 5; k++) begin
      chk("a_rr_ready", a_in_ready, 4'b0001 << (k % 4));
      q_a.push_back(mk(k % 4, 32'h10 + 32'(k % 4)));
      step();
    end
    a_in_valid = 4'h0;
    step();
    chk("a_rr_empty", a_out_valid, 0);

    // mid-stream asynchronous reset while stalled
    a_in_data[63:32] = 32'hDEAD_BEEF;
    a_in_valid = 4'b0010; a_out_ready = 1'b0;
    #1 chk("a_load_ready", a_in_ready, 4'b0010);
    step();
    a_in_valid = 4'b0101;
    step(); step();
    chk("a_stall_ready", a_in_ready, 4'h0);
    chk("a_stall_valid", a_out_valid, 1);
    chk("a_stall_data", a_out_data, 32'hDEAD_BEEF);
    chk("a_stall_ch", a_out_ch, 1);
    a_in_valid = 4'hF; a_out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_data", a_out_data, 0);
    chk("mid_rst_ch", a_out_ch, 0);
    chk("mid_rst_ready", a_in_ready, 4'h0);
    chk("mid_rst_ptr", u_a.ptr, 0);
    step();
    a_in_valid = 4'h0; a_in_data[63:32] = 32'h11;
    rst_n = 1'b1;
    step();

    // forced select leaves ptr untouched
    a_in_valid = 4'b0010;
    #1 chk("a_pre_force_ready", a_in_ready, 4'b0010);
    q_a.push_back(mk(1, 32'h11));
    step();
    chk("a_ptr_after_ch1", u_a.ptr, 2);
    a_force_en = 1'b1; a_force_sel = 2'd2; a_in_valid = 4'b1011;
    #1 chk("a_force_nogrant", a_in_ready, 4'h0);
    step();
    chk("a_force_drained", a_out_valid, 0);
    a_in_valid = 4'b0100; a_in_data[95:64] = 32'h77;
    #1 chk("a_force_ready", a_in_ready, 4'b0100);
    q_a.push_back(mk(2, 32'h77));
    step();
    chk("a_force_data", a_out_data, 32'h77);
    chk("a_force_ch", a_out_ch, 2);
    chk("a_force_ptr", u_a.ptr, 2);
    a_force_en = 1'b0; a_in_valid = 4'h0;
    step();

    // fixed priority
    b_in_data[63:32] = 32'hA1; b_in_data[127:96] = 32'hA3;
    b_in_valid = 4'b1010;
    #1 chk("b_fp_first", b_in_ready, 4'b0010);
    q_b.push_back(mk(1, 32'hA1));
    step();
    b_in_valid = 4'b1000;
    #1 chk("b_fp_second", b_in_ready, 4'b1000);
    q_b.push_back(mk(3, 32'hA3));
    step();
    b_in_data[31:0] = 32'hB0; b_in_data[127:96] = 32'hB3;
    b_in_valid = 4'b1001;
    #1 chk("b_fp_ch0_wins", b_in_ready, 4'b0001);
    q_b.push_back(mk(0, 32'hB0));
    step();
    b_in_valid = 4'b1000;
    q_b.push_back(mk(3, 32'hB3));
    step();
    b_in_valid = 4'h0;
    step();

    // backpressure with same-edge refill
    b_in_data[95:64] = 32'h55; b_in_valid = 4'b0100;
    q_b.push_back(mk(2, 32'h55));
    step();
    b_out_ready = 1'b0;
    b_in_data[31:0] = 32'hC0; b_in_data[63:32] = 32'hC1; b_in_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b_bp_ready", b_in_ready, 4'h0);
      chk("b_bp_valid", b_out_valid, 1);
      chk("b_bp_data", b_out_data, 32'h55);
      chk("b_bp_ch", b_out_ch, 2);
      step();
    end
    b_out_ready = 1'b1;
    #1 chk("b_refill_ready", b_in_ready, 4'b0001);
    q_b.push_back(mk(0, 32'hC0));
    step();
    b_in_valid = 4'b0010;
    q_b.push_back(mk(1, 32'hC1));
    step();
    b_in_valid = 4'h0;
    step();
    chk("b_idle_valid", b_out_valid, 0);
    chk("b_idle_data_kept", b_out_data, 32'hC1);
    chk("b_idle_ch_kept", b_out_ch, 1);

    // NCH=3 round-robin wrap and out-of-range force
    c_in_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("c_rr_ready", c_in_ready, 3'b001 << (k % 3));
      q_c.push_back(mk(k % 3, 32'h20 + 32'(k % 3)));
      step();
    end
    c_force_en = 1'b1; c_force_sel = 2'd3;
    #1 chk("c_force_oor_ready", c_in_ready, 3'b000);
    step(); step();
    chk("c_force_oor_valid", c_out_valid, 0);
    chk("c_force_oor_data", c_out_data, 32'h20);
    chk("c_ptr", u_c.ptr, 1);
    c_force_en = 1'b0; c_in_valid = 3'b000;
    step();

    chk("a_sb_left", 64'(q_a.size()), 0);
    chk("b_sb_left", 64'(q_b.size()), 0);
    chk("c_sb_left", 64'(q_c.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the combinational 2/3/4-way datapath selectors.
- NCH-input, WIDTH-bit selector with per-channel valid/ready handshake, fixed-priority or round-robin arbitration, and a forced-select override that reproduces the old control-driven mux behaviour.
- Result is held in a one-entry output register, so the block can sit between pipeline stages (e.g. writeback source select, memory-port sharing).

Parameters:
- WIDTH, 32, data width of every channel.
- NCH, 4, number of input channels; legal range 2..16.
- MODE, 1, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NCH  per-channel request; bit i belongs to channel i.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel accept, combinational; at most one bit high.
- force_en  in  1  when 1, arbitration is bypassed and only channel force_sel is eligible.
- force_sel  in  IDXW  forced channel index; IDXW = max(1, clog2(NCH)), derived, not a parameter.
- out_valid  out  1  output register holds a valid word.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  IDXW  index of the channel that supplied out_data.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is 0 throughout reset. A word held at reset time is dropped, not replayed.
- load_en = !out_valid | out_ready. The output register may take a new word only when load_en=1.
- Eligible set:
  - force_en=1: channel force_sel only, and only if in_valid[force_sel]=1.
  - force_sel >= NCH: no channel is eligible.
  - force_en=0: all channels with in_valid=1.
- Grant selection:
  - MODE=0: lowest eligible index.
  - MODE=1: first eligible index found searching ptr, ptr+1, ..., wrapping at NCH-1 -> 0.
  - force_en=1: the forced channel.
- Transfer: when load_en=1 and a grant g exists:
  - in_ready[g]=1; all other in_ready bits are 0.
  - At the clock edge: out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - In MODE=1 without force, ptr<=(g+1) mod NCH.
- ptr changes only on a transfer made while force_en=0. Forced transfers and stalls leave ptr unchanged. ptr is unused in MODE=0.
- When load_en=1 with no grant: all in_ready=0. If out_ready=1 (or the register was already empty), out_valid<=0 and out_data/out_ch keep their old values.
- Stall (out_valid=1 and out_ready=0): all in_ready=0, and out_valid/out_data/out_ch are held bit-stable.
- Simultaneous drain and refill (out_valid=1, out_ready=1, grant exists): the old word leaves and the new word loads on the same edge. This sustains 1 word/cycle.
- Latency: input accepted in cycle N appears on out_* in cycle N+1.
- Upstream rule: once in_valid[i] rises it stays high with in_data stable until in_ready[i]. The block does not check this rule.
- in_ready depends combinationally on in_valid, force_en, force_sel and out_ready. out_* are pure register outputs.
- Widths: no arithmetic on data. ptr and g are IDXW bits wide; the wrap is explicit so non-power-of-2 NCH works.

Test Plan:
- Reset mid-stream: out_valid=1, out_data=32'hDEAD_BEEF, stall, then pulse rst_n low -> out_valid=0, out_data=0, out_ch=0 immediately (no edge needed), in_ready=0 while low.
- MODE=1, NCH=4, all four in_valid held high with data 0x10..0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0,... one per cycle, out_data 0x10,0x11,0x12,0x13,0x10.
- MODE=0, channels 1 and 3 valid (0xA1, 0xA3), out_ready=1 -> 0xA1 (ch 1) first, 0xA3 (ch 3) next cycle. Then assert ch0 while ch3 is waiting -> ch0 wins.
- Backpressure: load 0x55 from ch2, hold out_ready=0 for 3 cycles with ch0/ch1 valid -> out_data stays 0x55, out_ch=2, in_ready=0. On the out_ready=1 cycle, ch0 (MODE=0) loads on the same edge.
- Force: force_en=1, force_sel=2, in_valid=4'b1011 -> no grant, out_valid falls after drain. Then in_valid[2]=1 with 0x77 -> out_data=0x77, out_ch=2, ptr unchanged.
- NCH=3, MODE=1, all valid: grants wrap 0,1,2,0. force_sel=3 -> no grant, all in_ready=0.
